// File: rtl/pps_conditioner_if.sv
// Signal bundle between the pps conditioner and its neighbours: raw pps in,
// clean strobe plus lock/holdover status and diagnostics out.
interface pps_conditioner_if #(
   parameter int CNT_BITS = 8
);
   logic                pps_raw;
   logic                pps_out;
   logic                locked;
   logic                holdover;
   logic [CNT_BITS-1:0] period;
   logic [3:0]          err_cnt;

   // Source side drives the raw pulse and consumes the conditioned result.
   modport master (
      output pps_raw,
      input  pps_out,
      input  locked,
      input  holdover,
      input  period,
      input  err_cnt
   );

   modport slave (
      input  pps_raw,
      output pps_out,
      output locked,
      output holdover,
      output period,
      output err_cnt
   );
endinterface

// File: rtl/pps_conditioner.sv
// Conditions a raw external pps into a one-cycle strobe: synchronise, edge-detect,
// measure the period, qualify lock, reject early edges and bridge dropouts.
module pps_conditioner #(
   parameter int SYNC_STAGES  = 2,
   parameter int NOMINAL      = 100,
   parameter int TOL          = 2,
   parameter int LOCK_COUNT   = 3,
   parameter int HOLDOVER_MAX = 5,
   parameter int CNT_BITS     = 8
) (
   input  logic             clk,
   input  logic             rst,
   pps_conditioner_if.slave pps_bus
);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(HOLDOVER_MAX + 1);

   localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
   localparam logic [CNT_BITS-1:0] WIN_LO     = CNT_BITS'(NOMINAL - TOL);
   localparam logic [CNT_BITS-1:0] WIN_HI     = CNT_BITS'(NOMINAL + TOL);
   localparam logic [CNT_BITS-1:0] TMO_VAL    = CNT_BITS'(NOMINAL + TOL + 1);
   localparam logic [CNT_BITS-1:0] RELOAD_VAL = CNT_BITS'(TOL + 1);
   localparam logic [GOOD_W-1:0]   GOOD_LOCK  = GOOD_W'(LOCK_COUNT);
   localparam logic [MISS_W-1:0]   MISS_LIMIT = MISS_W'(HOLDOVER_MAX);

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_QUALIFY,
      ST_LOCKED,
      ST_HOLDOVER
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_d;
   logic                   r_edge;

   state_t                 r_state;
   logic [CNT_BITS-1:0]    r_cnt;
   logic [GOOD_W-1:0]      r_good;
   logic [MISS_W-1:0]      r_missed;
   logic                   r_pps;
   logic                   r_locked;
   logic                   r_holdover;
   logic [CNT_BITS-1:0]    r_period;
   logic [3:0]             r_err;

   state_t                 w_state_nxt;
   logic [CNT_BITS-1:0]    w_cnt_nxt;
   logic [GOOD_W-1:0]      w_good_nxt;
   logic [MISS_W-1:0]      w_missed_nxt;
   logic                   w_pulse;
   logic                   w_err_inc;

   logic [CNT_BITS-1:0]    w_meas;
   logic [GOOD_W-1:0]      w_good_inc;
   logic [MISS_W-1:0]      w_missed_inc;
   logic                   w_in_win;
   logic                   w_timeout;

   // The registered edge adds the extra stage that puts pps_out SYNC_STAGES+1
   // cycles after the raw input is first sampled high.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for every flop so all of them sample pre-edge values.
      if (!rst) begin
         r_sync   <= '0;
         r_sync_d <= 1'b0;
         r_edge   <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], pps_bus.pps_raw};
         r_sync_d <= r_sync[SYNC_STAGES-1];
         r_edge   <= r_sync[SYNC_STAGES-1] & ~r_sync_d;
      end
   end

   // w_meas is the period an edge would measure this cycle; it saturates with r_cnt.
   assign w_meas       = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_BITS'(1);
   assign w_in_win     = (w_meas >= WIN_LO) && (w_meas <= WIN_HI);
   assign w_timeout    = (w_meas >= TMO_VAL);
   assign w_good_inc   = r_good + GOOD_W'(1);
   assign w_missed_inc = r_missed + MISS_W'(1);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      w_state_nxt  = r_state;
      w_cnt_nxt    = w_meas;
      w_good_nxt   = r_good;
      w_missed_nxt = r_missed;
      w_pulse      = 1'b0;
      w_err_inc    = 1'b0;

      case (r_state)
         ST_SEARCH: begin
            if (r_edge) begin
               w_state_nxt = ST_QUALIFY;
               w_good_nxt  = '0;
               w_cnt_nxt   = '0;
            end
         end

         ST_QUALIFY: begin
            if (w_timeout) begin
               w_state_nxt = ST_SEARCH;
               w_err_inc   = r_edge;
            end else if (r_edge) begin
               w_cnt_nxt = '0;
               if (w_in_win) begin
                  if (w_good_inc == GOOD_LOCK) begin
                     w_state_nxt = ST_LOCKED;
                     w_good_nxt  = '0;
                  end else begin
                     w_good_nxt = w_good_inc;
                  end
               end else begin
                  w_good_nxt = '0;
               end
            end
         end

         ST_LOCKED: begin
            if (w_timeout) begin
               // Reloading TOL+1 keeps synthetic pulses on the nominal grid.
               w_pulse      = 1'b1;
               w_missed_nxt = MISS_W'(1);
               w_cnt_nxt    = RELOAD_VAL;
               w_state_nxt  = ST_HOLDOVER;
               w_err_inc    = r_edge;
            end else if (r_edge) begin
               if (w_in_win) begin
                  w_pulse   = 1'b1;
                  w_cnt_nxt = '0;
               end else begin
                  w_err_inc = 1'b1;
               end
            end
         end

         ST_HOLDOVER: begin
            if (w_timeout) begin
               w_err_inc = r_edge;
               if (w_missed_inc == MISS_LIMIT) begin
                  w_state_nxt  = ST_SEARCH;
                  w_missed_nxt = '0;
               end else begin
                  w_pulse      = 1'b1;
                  w_missed_nxt = w_missed_inc;
                  w_cnt_nxt    = RELOAD_VAL;
               end
            end else if (r_edge) begin
               if (w_in_win) begin
                  w_pulse      = 1'b1;
                  w_missed_nxt = '0;
                  w_cnt_nxt    = '0;
                  w_state_nxt  = ST_LOCKED;
               end else begin
                  w_err_inc = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = ST_SEARCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_SEARCH;
         r_cnt      <= '0;
         r_good     <= '0;
         r_missed   <= '0;
         r_pps      <= 1'b0;
         r_locked   <= 1'b0;
         r_holdover <= 1'b0;
         r_period   <= '0;
         r_err      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_good     <= w_good_nxt;
         r_missed   <= w_missed_nxt;
         r_pps      <= w_pulse;
         r_locked   <= (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_HOLDOVER);
         r_holdover <= (w_state_nxt == ST_HOLDOVER);
         if (r_edge) begin
            r_period <= w_meas;
         end
         if (w_err_inc && (r_err != 4'hF)) begin
            r_err <= r_err + 4'd1;
         end
      end
   end

   assign pps_bus.pps_out  = r_pps;
   assign pps_bus.locked   = r_locked;
   assign pps_bus.holdover = r_holdover;
   assign pps_bus.period   = r_period;
   assign pps_bus.err_cnt  = r_err;
endmodule

// File: tb/tb_pps_conditioner.sv
// Bench for pps_conditioner: directed scenarios plus randomized edge spacing, every
// cycle compared against a timestamp-based model of the conditioning rules.
module tb_pps_conditioner;
   localparam int SYNC_STAGES  = 2;
   localparam int NOMINAL      = 100;
   localparam int TOL          = 2;
   localparam int LOCK_COUNT   = 3;
   localparam int HOLDOVER_MAX = 5;
   localparam int CNT_BITS     = 8;
   localparam int HIST         = SYNC_STAGES + 3;
   localparam int SAT          = (1 << CNT_BITS) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   pps_conditioner_if #(.CNT_BITS(CNT_BITS)) pps_bus ();

   pps_conditioner #(
      .SYNC_STAGES (SYNC_STAGES),
      .NOMINAL     (NOMINAL),
      .TOL         (TOL),
      .LOCK_COUNT  (LOCK_COUNT),
      .HOLDOVER_MAX(HOLDOVER_MAX),
      .CNT_BITS    (CNT_BITS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .pps_bus(pps_bus)
   );

   always #5 clk = ~clk;

   int n_checks   = 0;
   int n_fail     = 0;
   int pulse_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: tracks the time of the last phase reference instead of a counter.
   typedef enum {M_SEARCH, M_QUALIFY, M_LOCKED, M_HOLDOVER} mode_t;
   mode_t m_mode   = M_SEARCH;
   int    m_now    = 0;
   int    m_ref    = 0;
   int    m_good   = 0;
   int    m_missed = 0;
   int    m_err    = 0;
   int    m_period = 0;
   bit    m_pulse  = 1'b0;
   bit    m_hist [HIST];

   function automatic int err_bump(input int e);
      return (e < 15) ? e + 1 : 15;
   endfunction

   task automatic model_step(input logic rst_s, input logic raw_s);
      int meas;
      bit edge_seen;
      bit in_win;
      bit tmo;
      m_now++;
      m_pulse = 1'b0;
      if (!rst_s) begin
         m_mode   = M_SEARCH;
         m_ref    = m_now;
         m_good   = 0;
         m_missed = 0;
         m_err    = 0;
         m_period = 0;
         for (int i = 0; i < HIST; i++) m_hist[i] = 1'b0;
         return;
      end
      for (int i = HIST - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = raw_s;
      edge_seen = m_hist[SYNC_STAGES+1] && !m_hist[SYNC_STAGES+2];
      meas      = m_now - m_ref;
      if (meas > SAT) meas = SAT;
      in_win = (meas >= NOMINAL - TOL) && (meas <= NOMINAL + TOL);
      tmo    = (m_mode != M_SEARCH) && (meas >= NOMINAL + TOL + 1);
      if (edge_seen) m_period = meas;
      if (tmo && edge_seen) m_err = err_bump(m_err);
      case (m_mode)
         M_SEARCH: begin
            if (edge_seen) begin
               m_mode = M_QUALIFY;
               m_good = 0;
               m_ref  = m_now;
            end
         end
         M_QUALIFY: begin
            if (tmo) begin
               m_mode = M_SEARCH;
            end else if (edge_seen) begin
               m_ref  = m_now;
               m_good = in_win ? m_good + 1 : 0;
               if (m_good == LOCK_COUNT) m_mode = M_LOCKED;
            end
         end
         M_LOCKED: begin
            if (tmo) begin
               m_pulse  = 1'b1;
               m_missed = 1;
               m_ref    = m_ref + NOMINAL;
               m_mode   = M_HOLDOVER;
            end else if (edge_seen) begin
               if (in_win) begin
                  m_pulse = 1'b1;
                  m_ref   = m_now;
               end else begin
                  m_err = err_bump(m_err);
               end
            end
         end
         default: begin
            if (tmo) begin
               m_missed++;
               if (m_missed == HOLDOVER_MAX) begin
                  m_mode = M_SEARCH;
               end else begin
                  m_pulse = 1'b1;
                  m_ref   = m_ref + NOMINAL;
               end
            end else if (edge_seen) begin
               if (in_win) begin
                  m_pulse  = 1'b1;
                  m_missed = 0;
                  m_ref    = m_now;
                  m_mode   = M_LOCKED;
               end else begin
                  m_err = err_bump(m_err);
               end
            end
         end
      endcase
   endtask

   // Rising edge now, high for 'width' cycles, next edge 'gap' cycles later.
   task automatic pps_period(input int gap, input int width);
      pps_bus.pps_raw = 1'b1;
      repeat (width) @(negedge clk);
      pps_bus.pps_raw = 1'b0;
      repeat (gap - width) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] act;
      logic [31:0] exp;
      int p0;
      int gap;
      int width;
      int sel;

      pps_bus.pps_raw = 1'b0;
      rst             = 1'b0;

      fork
         forever begin
            @(posedge clk);
            model_step(rst, pps_bus.pps_raw);
            #1;
            act = {17'b0, pps_bus.pps_out, pps_bus.locked, pps_bus.holdover,
                   pps_bus.err_cnt, pps_bus.period};
            exp = {17'b0, m_pulse, (m_mode == M_LOCKED) || (m_mode == M_HOLDOVER),
                   m_mode == M_HOLDOVER, 4'(m_err), 8'(m_period)};
            check("cycle_outputs", act, exp);
            if (pps_bus.pps_out === 1'b1) pulse_seen++;
         end
      join_none

      // Reset held for three edges while the raw input toggles.
      repeat (3) begin
         @(negedge clk);
         pps_bus.pps_raw = ~pps_bus.pps_raw;
      end
      check("reset_outputs", 32'({pps_bus.pps_out, pps_bus.locked, pps_bus.holdover,
                                  pps_bus.err_cnt, pps_bus.period}), 32'd0);
      rst             = 1'b1;
      pps_bus.pps_raw = 1'b0;
      idle(20);

      // Lock acquisition: the fourth in-phase edge locks without a pulse.
      repeat (4) pps_period(NOMINAL, 10);
      check("lock_after_4th", 32'(pps_bus.locked), 32'd1);
      check("no_pulse_pre_lock", 32'(pulse_seen), 32'd0);

      // Fifth edge: strobe exactly SYNC_STAGES+1 cycles after first high sample, 1 wide.
      pps_bus.pps_raw = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1 check("latency_before", 32'(pps_bus.pps_out), 32'd0);
      @(posedge clk);
      #1 check("latency_hit", 32'(pps_bus.pps_out), 32'd1);
      @(posedge clk);
      #1 check("pulse_width", 32'(pps_bus.pps_out), 32'd0);
      @(negedge clk);
      pps_bus.pps_raw = 1'b0;
      idle(NOMINAL - 5);
      check("period_nominal", 32'(pps_bus.period), 32'd100);

      // Tolerance: 100, 98, 102 accepted, 97 rejected, then back on phase.
      p0 = pulse_seen;
      pps_period(98, 10);
      pps_period(102, 10);
      pps_period(97, 10);
      pps_period(3, 1);
      pps_period(NOMINAL, 10);
      check("tol_err_cnt", 32'(pps_bus.err_cnt), 32'd1);
      check("tol_pulses", 32'(pulse_seen - p0), 32'd4);
      check("tol_locked", 32'(pps_bus.locked), 32'd1);

      // Holdover: input stops; four synthetic pulses, fifth timeout drops to search.
      p0 = pulse_seen;
      idle(150);
      check("ho_flag", 32'(pps_bus.holdover), 32'd1);
      check("ho_locked", 32'(pps_bus.locked), 32'd1);
      idle(450);
      check("ho_pulses", 32'(pulse_seen - p0), 32'd4);
      check("ho_drop_locked", 32'(pps_bus.locked), 32'd0);
      check("ho_drop_flag", 32'(pps_bus.holdover), 32'd0);

      // Recovery: relock, miss two seconds, then resume on the nominal grid.
      p0 = pulse_seen;
      repeat (4) pps_period(NOMINAL, 10);
      idle(150);
      check("rec_in_holdover", 32'(pps_bus.holdover), 32'd1);
      idle(50);
      pps_period(NOMINAL, 10);
      check("rec_holdover_clr", 32'(pps_bus.holdover), 32'd0);
      check("rec_locked", 32'(pps_bus.locked), 32'd1);
      check("rec_pulses", 32'(pulse_seen - p0), 32'd3);

      // Glitch storm at half period: error count saturates, lock holds.
      repeat (40) pps_period(50, 5);
      check("err_saturate", 32'(pps_bus.err_cnt), 32'd15);
      check("glitch_locked", 32'(pps_bus.locked), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_err", 32'(pps_bus.err_cnt), 32'd0);
      check("midrst_locked", 32'(pps_bus.locked), 32'd0);
      repeat (6) pps_period(50, 5);

      // Randomized spacing: mostly near nominal, some early glitches, some dropouts.
      repeat (80) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 6) begin
            gap = NOMINAL - (TOL + 1) + int'($urandom_range(0, 2 * TOL + 2));
         end else if (sel < 8) begin
            gap = int'($urandom_range(20, 95));
         end else begin
            gap = int'($urandom_range(104, 260));
         end
         width = 1 + int'($urandom_range(0, 15));
         pps_period(gap, width);
      end
      idle(600);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
